// File: rtl/comparador_serial_if.sv
// ---------------------------------------------------------------------------
// comparador_serial_if
//   Handshake/data bundle between a controller and the bit-serial comparator.
//   Signals:
//     start  controller -> comparator  request a compare of wordA/wordB
//     wordA  controller -> comparator  operand A (unsigned, WIDTH bits)
//     wordB  controller -> comparator  operand B (unsigned, WIDTH bits)
//     w      comparator -> controller  1 when A > B
//     z      comparator -> controller  1 when A <= B
//     busy   comparator -> controller  1 while a scan is running
//     done   comparator -> controller  one-cycle pulse when a new result appears
//   Modports: master = controller side, slave = comparator side.
// ---------------------------------------------------------------------------
interface comparador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] wordA;
  logic [WIDTH-1:0] wordB;
  logic             w;
  logic             z;
  logic             busy;
  logic             done;

  modport master (
    output start, wordA, wordB,
    input  w, z, busy, done
  );

  modport slave (
    input  start, wordA, wordB,
    output w, z, busy, done
  );
endinterface

// File: rtl/comparador_serial.sv
// ---------------------------------------------------------------------------
// comparador_serial
//   Bit-serial unsigned magnitude comparator. Operands are latched on start
//   and scanned MSB first, one bit per clock; the scan stops at the first
//   differing bit. Result code: (w,z) = (1,0) for A > B, (0,1) for A <= B.
//   (0,0) only ever appears after reset ("no result yet").
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    comparador_serial_if.slave (start, wordA, wordB, w, z, busy, done)
//   Latency: with the start edge as edge 0, a first difference at bit i is
//   decided at edge WIDTH-i; done is high in the following cycle.
// ---------------------------------------------------------------------------
module comparador_serial #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  comparador_serial_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             w_q, w_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    index_d = index_q;
    w_d     = w_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ra_d    = bus.wordA;
          rb_d    = bus.wordB;
          index_d = IDX_MSB;
          state_d = SCAN;
        end
      end

      SCAN: begin
        // start is deliberately not looked at here: a running scan cannot
        // be restarted.
        if (ra_q[index_q] != rb_q[index_q]) begin
          // First differing bit decides: A has the 1 -> A > B.
          w_d     = ra_q[index_q];
          z_d     = ~ra_q[index_q];
          state_d = DONE;
        end else if (index_q == '0) begin
          // All bits matched: equal counts as A <= B.
          w_d     = 1'b0;
          z_d     = 1'b1;
          state_d = DONE;
        end else begin
          index_d = index_q - IDX_W'(1);
        end
      end

      DONE: begin
        // Back-to-back compare: a start seen in the done cycle is accepted
        // without passing through IDLE.
        if (bus.start) begin
          ra_d    = bus.wordA;
          rb_d    = bus.wordB;
          index_d = IDX_MSB;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered and follow the state being entered.
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      index_q <= IDX_MSB;
      w_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      index_q <= index_d;
      w_q     <= w_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.w    = w_q;
  assign bus.z    = z_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_comparador_serial.sv
// ---------------------------------------------------------------------------
// tb_comparador_serial
//   Directed bench for comparador_serial (WIDTH=8). The driver issues
//   compares and pushes hand-computed (w, z, latency) into a scoreboard
//   queue; an independent monitor pops one entry per done pulse.
// ---------------------------------------------------------------------------
module tb_comparador_serial;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  comparador_serial_if #(.WIDTH(WIDTH)) bus ();

  comparador_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic  w;
    logic  z;
    int    lat;
    int    t0;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic last_w = 1'b0;
  logic last_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding compare.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_w"}, 32'(bus.w), 32'(mon_e.w));
        check({mon_e.tag, "_z"}, 32'(bus.z), 32'(mon_e.z));
        check({mon_e.tag, "_latency"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        check({mon_e.tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        last_w = mon_e.w;
        last_z = mon_e.z;
        $display("done %s: w=%0b z=%0b latency=%0d", mon_e.tag, bus.w, bus.z, cyc - mon_e.t0);
      end
    end
  end

  // Call at a negedge with the DUT in IDLE or DONE. Returns at the negedge
  // after the start edge, with operands scrambled to prove they were latched.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic ew, input logic ez, input int lat, input string tag);
    exp_t e;
    bus.start = 1'b1;
    bus.wordA = a;
    bus.wordB = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.wordA = 8'($urandom);
    bus.wordB = 8'($urandom);
    e.w   = ew;
    e.z   = ez;
    e.lat = lat;
    e.t0  = cyc;
    e.tag = tag;
    sb.push_back(e);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       w;
    logic       z;
    int         lat;
    string      tag;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b1, 8, "t1_eq_zero"};
    vecs[1] = '{8'h6E, 8'h01, 1'b1, 1'b0, 2, "t2_bit6"};
    vecs[2] = '{8'h6E, 8'h6F, 1'b0, 1'b1, 8, "t3_bit0"};
    vecs[3] = '{8'h00, 8'h80, 1'b0, 1'b1, 1, "msb_lt"};
    vecs[4] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 8, "lsb_gt"};

    bus.start = 1'b0;
    bus.wordA = '0;
    bus.wordB = '0;

    // Reset state
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_w", 32'(bus.w), 32'd0);
    check("rst_z", 32'(bus.z), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single compares, each returning to IDLE, then checking the held result
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].z, vecs[i].lat, vecs[i].tag);
      wait_done(20);
      repeat (3) @(negedge clk);
      check({vecs[i].tag, "_hold_w"}, 32'(bus.w), 32'(vecs[i].w));
      check({vecs[i].tag, "_hold_z"}, 32'(bus.z), 32'(vecs[i].z));
      check({vecs[i].tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    end

    // Back-to-back: second start presented during the done cycle
    issue(8'hF2, 8'hE9, 1'b1, 1'b0, 4, "t4a");
    wait_done(20);
    issue(8'hCB, 8'h81, 1'b1, 1'b0, 2, "t4b");
    wait_done(20);
    @(negedge clk);

    // start during a scan is ignored
    issue(8'h01, 8'h00, 1'b1, 1'b0, 8, "t5");
    @(negedge clk);
    bus.start = 1'b1;
    bus.wordA = 8'h00;
    bus.wordB = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(20);
    repeat (10) @(negedge clk);
    check("t5_queue_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of an equal-operand scan
    issue(8'h55, 8'h55, 1'b0, 1'b1, 8, "t6");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_w", 32'(bus.w), 32'd0);
    check("t6_rst_z", 32'(bus.z), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_after_w", 32'(bus.w), 32'd0);
    check("t6_after_z", 32'(bus.z), 32'd0);
    check("t6_after_busy", 32'(bus.busy), 32'd0);

    // Recovery after abort
    issue(8'h80, 8'h7F, 1'b1, 1'b0, 1, "post_rst");
    wait_done(20);
    repeat (2) @(negedge clk);
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
